// File: rtl/data_memory.sv
// Word-organised 16-bit data memory: synchronous store, combinational load.
// The byte address from the ALU is reduced to a word index; unused bits alias.
module data_memory #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] DMem_In,
  input  logic [15:0] Data_Write,
  input  logic        Mem_Write,
  input  logic        Mem_Read,
  output logic [15:0] DataM_out
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_BITS;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0] word_idx;
  logic                 unused_addr;

  // Bit 0 selects a byte within the word and high bits alias; neither affects indexing.
  assign word_idx    = DMem_In[ADDR_BITS:1];
  assign unused_addr = ^{DMem_In[0], DMem_In >> (ADDR_BITS + 1)};

  // Reset clears every word asynchronously; otherwise one word is stored per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_BITS'(i)] <= '0;
      end
    end else if (Mem_Write) begin
      mem[word_idx] <= Data_Write;
    end
  end

  // Load path is combinational and gated to zero when no read is requested.
  assign DataM_out = Mem_Read ? mem[word_idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected load values,
// a negedge monitor pops and compares them against DataM_out.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic [15:0] DMem_In;
  logic [15:0] Data_Write;
  logic        Mem_Write;
  logic        Mem_Read;
  logic [15:0] DataM_out;

  data_memory #(.ADDR_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .DMem_In   (DMem_In),
    .Data_Write(Data_Write),
    .Mem_Write (Mem_Write),
    .Mem_Read  (Mem_Read),
    .DataM_out (DataM_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of 256 words indexed by byte address / 2.
  logic [15:0] ref_mem [256];
  logic [15:0] exp_q [$];
  string       name_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          stim_done = 1'b0;

  function automatic int word_of(input logic [15:0] a);
    return (int'(a) / 2) % 256;
  endfunction

  task automatic clear_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
  endtask

  // One bus cycle: drive between edges, record the load value expected before the next edge.
  task automatic cycle(input logic rst, input logic [15:0] addr, input logic [15:0] data,
                       input logic we, input logic rd, input string name);
    @(posedge clk);
    #1;
    rst_n      = rst;
    if (!rst) clear_ref();
    DMem_In    = addr;
    Data_Write = data;
    Mem_Write  = we;
    Mem_Read   = rd;
    exp_q.push_back(rd ? ref_mem[word_of(addr)] : 16'h0000);
    name_q.push_back(name);
    if (we && rst) ref_mem[word_of(addr)] = data;
  endtask

  // Monitor: load data is valid mid-cycle, so compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [15:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        n_checks++;
        if (DataM_out === e) n_pass++;
        else $display("FAIL %s: DataM_out=%h expected=%h at %0t", n, DataM_out, e, $time);
      end
    end
  end

  initial begin
    rst_n = 1'b0; DMem_In = '0; Data_Write = '0; Mem_Write = 1'b0; Mem_Read = 1'b0;
    clear_ref();

    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "rst_hold");
    cycle(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, "rst_rd_0000");
    cycle(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b1, "rst_rd_0004");
    cycle(1'b1, 16'hFFFE, 16'h0000, 1'b0, 1'b1, "rst_rd_fffe");

    cycle(1'b1, 16'h0004, 16'hABCD, 1'b1, 1'b0, "wr_0004_gated");
    cycle(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b1, "rd_0004");
    cycle(1'b1, 16'hFFFE, 16'h1234, 1'b1, 1'b0, "wr_fffe_gated");
    cycle(1'b1, 16'hFFFE, 16'h0000, 1'b0, 1'b1, "rd_fffe");
    cycle(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b1, "rd_0004_kept");

    cycle(1'b1, 16'h0006, 16'h5678, 1'b1, 1'b1, "rw_0006_pre");
    cycle(1'b1, 16'h0006, 16'h0000, 1'b0, 1'b1, "rw_0006_post");

    cycle(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b0, "rd_gate_off");
    cycle(1'b1, 16'h0005, 16'h0000, 1'b0, 1'b1, "rd_bit0_ignored");
    cycle(1'b1, 16'h0204, 16'h0000, 1'b0, 1'b1, "rd_alias_0204");

    cycle(1'b1, 16'h0006, 16'h1111, 1'b1, 1'b0, "b2b_wr_a");
    cycle(1'b1, 16'h0007, 16'h2222, 1'b1, 1'b0, "b2b_wr_b");
    cycle(1'b1, 16'h0006, 16'h0000, 1'b0, 1'b1, "b2b_last_wins");

    // Random traffic over a 16-word window with random byte-select and alias bits.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      a = 16'($urandom) & 16'hF81F;
      cycle(1'b1, a, 16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), "random");
    end

    cycle(1'b1, 16'h0004, 16'hBEEF, 1'b1, 1'b0, "pre_rst_wr");
    cycle(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b1, "pre_rst_rd");
    cycle(1'b0, 16'h0004, 16'h0000, 1'b0, 1'b1, "async_rst_clear");
    cycle(1'b0, 16'h0004, 16'hDEAD, 1'b1, 1'b1, "wr_during_rst");
    cycle(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b1, "rst_release");
    cycle(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b1, "wr_in_rst_dropped");
    cycle(1'b1, 16'hFFFE, 16'h0000, 1'b0, 1'b1, "rst_cleared_fffe");

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    n_checks++;
    if (stim_done && exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: stim_done=%0d pending=%0d required 1/0", stim_done, exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
